// File: rtl/dual_port_ram_arbiter_pkg.sv
// Shared types for the two-requester RAM arbiter: FSM state encoding and requester count.
package dual_port_ram_arbiter_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_DATA,
      RESP
   } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin selector: a lone requester always wins, a tie goes to rr_ptr.
module rr_arbiter_2
   import dual_port_ram_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               rr_ptr,
   output logic [NUM_REQ-1:0] gnt
);

   always_comb begin
      gnt = '0;
      if (req == 2'b11) begin
         gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// Arbitrates two requesters onto one asynchronous-style SRAM with a shared bidirectional data bus.
// Writes take one bus cycle, reads take an address cycle plus an output-enable cycle.
module dual_port_ram_arbiter
   import dual_port_ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          ram_cs,
   output logic                          ram_we,
   output logic                          ram_oe,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   output logic [DATA_WIDTH-1:0]         ram_wdata,
   output logic                          ram_wdata_en,
   input  logic [DATA_WIDTH-1:0]         ram_rdata
);

   state_t                state;
   state_t                next_state;
   logic                  rr_ptr;
   logic                  grant_idx;
   logic                  lat_we;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [NUM_REQ-1:0]    gnt;
   logic                  win_idx;
   logic                  accept;

   rr_arbiter_2 u_arb (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .gnt    (gnt)
   );

   assign win_idx   = gnt[1];
   assign accept    = (state == IDLE) && (gnt != '0);
   assign req_ready = (state == IDLE) ? gnt : '0;
   assign ram_addr  = lat_addr;
   assign ram_wdata = lat_wdata;

   // The winner's request is captured on accept so the requester may change its inputs freely afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         grant_idx <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rsp_rdata <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            grant_idx <= win_idx;
            lat_we    <= req_we[win_idx];
            lat_addr  <= req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wdata <= req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr    <= ~win_idx;
         end
         if (state == RD_DATA) begin
            rsp_rdata <= ram_rdata;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = req_we[win_idx] ? WR : RD_ADDR;
         WR:      next_state = RESP;
         RD_ADDR: next_state = RD_DATA;
         RD_DATA: next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Bus strobes are forced low while reset is held so a mid-operation reset never drives the RAM.
   always_comb begin
      ram_cs       = 1'b0;
      ram_we       = 1'b0;
      ram_oe       = 1'b0;
      ram_wdata_en = 1'b0;
      rsp_valid    = '0;
      case (state)
         WR: begin
            ram_cs       = 1'b1;
            ram_we       = 1'b1;
            ram_wdata_en = 1'b1;
         end
         RD_ADDR: ram_cs = 1'b1;
         RD_DATA: begin
            ram_cs = 1'b1;
            ram_oe = 1'b1;
         end
         RESP:    rsp_valid[grant_idx] = 1'b1;
         default: ;
      endcase
      if (rst) begin
         ram_cs       = 1'b0;
         ram_we       = 1'b0;
         ram_oe       = 1'b0;
         ram_wdata_en = 1'b0;
         rsp_valid    = '0;
      end
   end

endmodule

// File: doc/dual_port_ram_arbiter.md
DUAL_PORT_RAM_ARBITER -- requirements
Module: dual_port_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, RAM data width.
REQ-003 clk  input  1  single clock, all logic on posedge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  2  per-requester request strobe, bit i = requester i.
REQ-006 req_we  input  2  per-requester op: 1 = write, 0 = read.
REQ-007 req_addr  input  2*ADDR_WIDTH  requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_wdata  input  2*DATA_WIDTH  requester i write data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready  output  2  one-hot accept; a request transfers when req_valid[i] & req_ready[i].
REQ-010 rsp_valid  output  2  one-cycle completion pulse to the owning requester.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data, valid while rsp_valid is high for a read.
REQ-012 ram_cs, ram_we, ram_oe  output  1 each  RAM chip select, write enable, output enable.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 ram_wdata  output  DATA_WIDTH, plus ram_wdata_en output 1: write data and tri-state drive enable for the shared bidirectional RAM data bus.
REQ-015 ram_rdata  input  DATA_WIDTH  value sampled from the RAM data bus.

Function
REQ-016 FSM states SHALL be IDLE, WR, RD_ADDR, RD_DATA, RESP.
REQ-017 req_ready SHALL be nonzero only in IDLE, and SHALL be combinational from req_valid and the round-robin pointer.
REQ-018 Arbitration rule: with one valid requester, that requester wins; with both valid, the requester selected by pointer rr_ptr wins.
REQ-019 On accept, rr_ptr SHALL be set to the non-winning index; with no accept, rr_ptr SHALL hold.
REQ-020 On accept, the block SHALL latch grant index, we, addr and wdata, then go to WR (write) or RD_ADDR (read).
REQ-021 WR state: ram_cs=1, ram_we=1, ram_oe=0, ram_wdata_en=1; next state RESP.
REQ-022 RD_ADDR state: ram_cs=1, ram_we=0, ram_oe=0; next state RD_DATA.
REQ-023 RD_DATA state: ram_cs=1, ram_we=0, ram_oe=1, address held; ram_rdata registered into rsp_rdata at the end of the state; next state RESP.
REQ-024 RESP state: rsp_valid[grant]=1 for exactly one cycle; next state IDLE.
REQ-025 In all other states, ram_cs, ram_we, ram_oe and ram_wdata_en SHALL be 0, and ram_addr and ram_wdata SHALL hold the latched values.
REQ-026 Latency, with accept in cycle T: write completes in RAM at T+1, rsp_valid at T+2; read rsp_valid and rsp_rdata at T+3.
REQ-027 Next accept earliest at T+3 (write) or T+4 (read); req_valid and req_addr changes during an operation SHALL be ignored.
REQ-028 ram_we=1 and ram_oe=1 SHALL never be asserted in the same cycle.
REQ-029 rsp_rdata SHALL hold its last read value across writes and idle cycles.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, rr_ptr=0, rsp_rdata=0, and latched addr, wdata and grant are 0.
REQ-031 During and directly after reset, all ram_* strobes and rsp_valid SHALL be 0, and req_ready follows REQ-017 from IDLE.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no rsp_valid; a partially issued write is permitted to have completed.

Structure
REQ-033 Shared package dual_port_ram_arbiter_pkg SHALL hold the FSM state enum and the requester count constant NUM_REQ=2.
REQ-034 The round-robin selection SHALL be sub-module rr_arbiter_2 (inputs req[1:0] and rr_ptr, output one-hot gnt[1:0]).

Verification
REQ-035 After reset, requester 0 writes addr 3, data 0xDEADBEEF -> ram_cs=ram_we=1 with ram_addr=3 one cycle after accept, then rsp_valid=2'b01.
REQ-036 Requester 1 then reads addr 3 -> rsp_valid=2'b10 three cycles after accept with rsp_rdata=0xDEADBEEF.
REQ-037 Both requesters hold req_valid=1 for 4 operations after reset -> grant order 0,1,0,1.
REQ-038 Requester 1 alone issues back-to-back reads -> accepts spaced exactly 4 cycles apart, and rsp_rdata is stable between responses.
REQ-039 rst pulsed during RD_DATA -> no rsp_valid, state IDLE, rsp_rdata=0, and the next request is accepted normally.
REQ-040 Write addr 15 (wrap boundary), then read addr 15 and addr 0 -> correct data and no aliasing.
